// File: rtl/mult_pkg.sv
// Shared constants for the radix-4 sequential multiplier:
// FSM state encoding and radix-4 digit values.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIG_ZERO  = 2'd0;
    localparam logic [1:0] DIG_ONE   = 2'd1;
    localparam logic [1:0] DIG_TWO   = 2'd2;
    localparam logic [1:0] DIG_THREE = 2'd3;

endpackage

// File: rtl/radix4_digit_mux.sv
// Radix-4 partial product selector: maps a 2-bit digit to
// 0, A, 2A or 3A, widened by two bits so 3A never overflows.
module radix4_digit_mux
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       d,
    output logic [WIDTH+1:0] y
);

    logic [WIDTH+1:0] a_ext;

    assign a_ext = {2'b00, a};

    always_comb begin
        y = '0;
        unique case (d)
            DIG_ZERO:  y = '0;
            DIG_ONE:   y = a_ext;
            DIG_TWO:   y = a_ext << 1;
            DIG_THREE: y = (a_ext << 1) + a_ext;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/seq_mult_radix4.sv
// Iterative signed/unsigned multiplier retiring two multiplier
// bits per clock, with a start/busy/done handshake.
module seq_mult_radix4
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic               iSigned,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    output logic               oBusy,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oResult
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               neg;
    logic [2*WIDTH-1:0] p;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH-1:0] p_next;
    logic [2*WIDTH-1:0] prod_fix;

    // Magnitude of the most negative value wraps to 2^(W-1) unsigned.
    assign a_abs = (iSigned && iA[WIDTH-1]) ? -iA : iA;
    assign b_abs = (iSigned && iB[WIDTH-1]) ? -iB : iB;

    radix4_digit_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a(a_reg),
        .d(b_reg[1:0]),
        .y(addend)
    );

    assign sum      = {2'b00, p[2*WIDTH-1:WIDTH]} + addend;
    assign p_next   = {sum, p[WIDTH-1:2]};
    assign prod_fix = neg ? -p_next : p_next;

    // The result is registered on the final step so that the
    // done pulse and the valid product appear in the DONE cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            neg     <= 1'b0;
            p       <= '0;
            cnt     <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oResult <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        a_reg <= a_abs;
                        b_reg <= b_abs;
                        neg   <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                        p     <= '0;
                        cnt   <= '0;
                        oBusy <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    p     <= p_next;
                    b_reg <= b_reg >> 2;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        oResult <= prod_fix;
                        oDone   <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_radix4.sv
// Self-checking bench for seq_mult_radix4 (WIDTH=8): directed
// table, handshake corner cases and a randomized model sweep.
module tb_seq_mult_radix4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] res;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_mult_radix4 #(
        .WIDTH(8)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .iStart(start),
        .iSigned(sgn),
        .iA(a),
        .iB(b),
        .oBusy(busy),
        .oDone(done),
        .oResult(res)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    function automatic void check(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [15:0] model(logic [7:0] x,
                                          logic [7:0] y,
                                          logic s);
        int r;
        if (s)
            r = int'($signed(x)) * int'($signed(y));
        else
            r = int'(x) * int'(y);
        return r[15:0];
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_mult(input logic [7:0] x, input logic [7:0] y,
                           input logic s, input logic [15:0] exp,
                           input string nm);
        int n;
        @(negedge clk);
        a = x;
        b = y;
        sgn = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sgn = 1'($urandom);
        check({nm, " busy"}, int'(busy), 1);
        wait_done(n);
        check({nm, " latency"}, n, 4);
        check({nm, " result"}, int'(res), int'(exp));
        @(posedge clk);
        #1;
        check({nm, " done pulse"}, int'(done), 0);
        check({nm, " busy low"}, int'(busy), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   n;
        int   dones;
        logic [7:0] x;
        logic [7:0] y;
        logic s;

        tbl[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
        tbl[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        tbl[2] = '{8'd0,   8'd200, 1'b0, 16'h0000};
        tbl[3] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
        tbl[4] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        tbl[5] = '{8'h80,  8'h01,  1'b1, 16'hFF80};

        rst = 1'b1;
        start = 1'b0;
        sgn = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset result", int'(res), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_mult(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp,
                    $sformatf("tbl%0d", i));

        // Restart attempts during BUSY must be ignored.
        @(negedge clk);
        a = 8'd13;
        b = 8'd11;
        sgn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd2;
        b = 8'd2;
        wait_done(n);
        check("restart latency", n, 4);
        check("restart result", int'(res), 16'h008F);
        dones = 0;
        @(posedge clk);
        #1;
        dones += int'(done);
        check("restart busy low", int'(busy), 0);
        // start still high: accepted on first IDLE cycle
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy", int'(busy), 1);
        wait_done(n);
        check("b2b extra done", dones, 0);
        check("b2b latency", n, 4);
        check("b2b result", int'(res), 16'h0004);
        @(posedge clk);
        #1;

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        a = 8'd255;
        b = 8'd255;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort result", int'(res), 0);
        dones = 0;
        repeat (8) begin
            dones += int'(done);
            @(posedge clk);
            #1;
        end
        check("abort no done", dones, 0);
        do_mult(8'd7, 8'd9, 1'b0, 16'h003F, "after abort");

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'(i & 1);
            if ((i % 97) == 0) x = 8'h80;
            if ((i % 89) == 0) y = 8'h00;
            do_mult(x, y, s, model(x, y, s),
                    $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
